// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/blank generator with registered decodes and an early FIFO read request.
// Optional display window gating is compiled in with `define VGA_WINDOW_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PREFETCH = 2,
  parameter int CW       = 12,
  parameter int WIN_X0   = 480,
  parameter int WIN_Y0   = 360,
  parameter int WIN_W    = 160,
  parameter int WIN_H    = 120
) (
  input  logic          vga_clk,
  input  logic          reset,
  output logic          HS,
  output logic          VS,
  output logic          blank_n,
  output logic          rd_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0     = H_SYNC + H_BACK;
  localparam int VA0     = V_SYNC + V_BACK;

  localparam logic [CW:0]   H_LAST   = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0]   V_LAST   = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0]   HA_START = (CW+1)'(HA0);
  localparam logic [CW:0]   HA_END   = (CW+1)'(HA0 + H_ACTIVE);
  localparam logic [CW:0]   VA_START = (CW+1)'(VA0);
  localparam logic [CW:0]   VA_END   = (CW+1)'(VA0 + V_ACTIVE);
  localparam logic [CW:0]   HS_END   = (CW+1)'(H_SYNC);
  localparam logic [CW:0]   VS_END   = (CW+1)'(V_SYNC);
  localparam logic [CW:0]   PF       = (CW+1)'(PREFETCH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Elaboration-time sanity checks on the timing configuration.
  if (PREFETCH < 0 || PREFETCH > H_BACK) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH must lie in 0..H_BACK");
  end
  if (WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE) begin : g_bad_window
    $error("vga_timing_gen: window must fit inside the active area");
  end
  if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          blank_n_q, blank_n_d, rd_req_q, rd_req_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic          frame_start_q, frame_start_d, line_start_q, line_start_d;

  logic [CW:0]   h_ext, v_ext, h_pf;
  logic          h_act, v_act, pf_act, disp, req;
  logic [CW-1:0] px_rel, py_rel;
`ifdef VGA_WINDOW_EN
  localparam logic [CW:0] WX_LO = (CW+1)'(WIN_X0);
  localparam logic [CW:0] WX_HI = (CW+1)'(WIN_X0 + WIN_W);
  localparam logic [CW:0] WY_LO = (CW+1)'(WIN_Y0);
  localparam logic [CW:0] WY_HI = (CW+1)'(WIN_Y0 + WIN_H);
  logic [CW:0]   pf_rel;
`endif

  always_comb begin
    // One extra bit so h_cnt+PREFETCH cannot wrap.
    h_ext  = {1'b0, h_cnt_q};
    v_ext  = {1'b0, v_cnt_q};
    h_pf   = h_ext + PF;
    h_act  = (h_ext >= HA_START) && (h_ext < HA_END);
    v_act  = (v_ext >= VA_START) && (v_ext < VA_END);
    pf_act = (h_pf >= HA_START) && (h_pf < HA_END);
    px_rel = CW'(h_ext - HA_START);
    py_rel = CW'(v_ext - VA_START);
    disp   = h_act && v_act;
    req    = pf_act && v_act;
`ifdef VGA_WINDOW_EN
    pf_rel = h_pf - HA_START;
    disp   = disp && ({1'b0, px_rel} >= WX_LO) && ({1'b0, px_rel} < WX_HI)
                  && ({1'b0, py_rel} >= WY_LO) && ({1'b0, py_rel} < WY_HI);
    req    = req && (pf_rel >= WX_LO) && (pf_rel < WX_HI)
                 && ({1'b0, py_rel} >= WY_LO) && ({1'b0, py_rel} < WY_HI);
`endif

    hs_d          = (h_ext < HS_END) ? HS_POL : ~HS_POL;
    vs_d          = (v_ext < VS_END) ? VS_POL : ~VS_POL;
    blank_n_d     = disp;
    rd_req_d      = req;
    pix_x_d       = (h_act && v_act) ? px_rel : '0;
    pix_y_d       = (h_act && v_act) ? py_rel : '0;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    line_start_d  = (h_cnt_q == '0);

    h_cnt_d = h_cnt_q + ONE;
    v_cnt_d = v_cnt_q;
    if (h_ext == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_ext == V_LAST) ? '0 : v_cnt_q + ONE;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b0;
      rd_req_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rd_req_q      <= rd_req_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign HS          = hs_q;
  assign VS          = vs_q;
  assign blank_n     = blank_n_q;
  assign rd_req      = rd_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule
